// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive path.
// Frame layout: start, 8 data bits LSB-first, parity, stop.
package uart_pkg;

  localparam int FRAME_W      = 11;
  localparam int DATA_W       = 8;
  localparam int START_BIT    = 10;
  localparam int DATA_MSB_POS = 9;
  localparam int DATA_LSB_POS = 2;
  localparam int PARITY_BIT   = 1;
  localparam int STOP_BIT     = 0;

  // Data bit 0 arrives first, so it sits in the highest data position.
  function automatic logic [DATA_W-1:0] frame_to_byte(
    input logic [FRAME_W-1:0] frame
  );
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] b;
    raw = frame[DATA_MSB_POS:DATA_LSB_POS];
    for (int i = 0; i < DATA_W; i++)
      b[i] = raw[DATA_W-1-i];
    return b;
  endfunction

  function automatic logic even_parity(
    input logic [DATA_W-1:0] b
  );
    return ^b;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Small synchronous FIFO with a registered head that
// holds its last value while the FIFO is empty.
module uart_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [W-1:0]  head_next;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    rd_next    = do_pop ? rd + AW'(1) : rd;
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + (AW+1)'(1);
    else if (do_pop && !do_push)
      count_next = count - (AW+1)'(1);
    // A write landing in the slot about to become head must be forwarded.
    head_next = mem[rd_next];
    if (do_push && rd_next == wr)
      head_next = wdata;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
      head  <= '0;
    end else begin
      rd    <= rd_next;
      count <= count_next;
      if (do_push)
        wr <= wr + AW'(1);
      if (count_next != '0)
        head <= head_next;
    end
  end

endmodule

// File: rtl/uart_frame_checker.sv
// Checks captured UART frames, queues good bytes for the host
// and keeps saturating error counters plus a sticky overflow flag.
module uart_frame_checker
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               UART_CLK,
  input  logic               UART_RESET,
  input  logic [FRAME_W-1:0] Packet_In,
  input  logic               Packet_Valid,
  output logic [DATA_W-1:0]  Data_Out,
  output logic               Data_Valid,
  input  logic               Data_Ready,
  output logic [CNT_W-1:0]   Parity_Err_Cnt,
  output logic [CNT_W-1:0]   Frame_Err_Cnt,
  output logic               Overflow,
  input  logic               Clear_Status
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] data_byte;
  logic framing_err;
  logic parity_err;
  logic good;
  logic perr_inc;
  logic ferr_inc;
  logic pop;
  logic push;
  logic drop;
  logic full;
  logic empty;

  assign data_byte   = frame_to_byte(Packet_In);
  assign framing_err = Packet_In[START_BIT] | ~Packet_In[STOP_BIT];
  assign parity_err  = Packet_In[PARITY_BIT] != even_parity(data_byte);

  // Framing errors take precedence over parity errors.
  assign good     = Packet_Valid & ~framing_err & ~parity_err;
  assign ferr_inc = Packet_Valid & framing_err;
  assign perr_inc = Packet_Valid & ~framing_err & parity_err;

  assign Data_Valid = ~empty;
  assign pop        = Data_Valid & Data_Ready;
  assign push       = good & (~full | pop);
  assign drop       = good & full & ~pop;

  uart_byte_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (UART_CLK),
    .rst   (UART_RESET),
    .push  (push),
    .pop   (pop),
    .wdata (data_byte),
    .head  (Data_Out),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge UART_CLK) begin
    if (UART_RESET || Clear_Status) begin
      Parity_Err_Cnt <= '0;
      Frame_Err_Cnt  <= '0;
      Overflow       <= 1'b0;
    end else begin
      if (perr_inc && Parity_Err_Cnt != CNT_MAX)
        Parity_Err_Cnt <= Parity_Err_Cnt + CNT_W'(1);
      if (ferr_inc && Frame_Err_Cnt != CNT_MAX)
        Frame_Err_Cnt <= Frame_Err_Cnt + CNT_W'(1);
      if (drop)
        Overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_frame_checker.sv
// Directed bench for uart_frame_checker with a scoreboard queue
// of expected bytes drained by an independent output monitor.
module tb_uart_frame_checker;

  logic        UART_CLK = 1'b0;
  logic        UART_RESET;
  logic [10:0] Packet_In;
  logic        Packet_Valid;
  logic [7:0]  Data_Out;
  logic        Data_Valid;
  logic        Data_Ready;
  logic [7:0]  Parity_Err_Cnt;
  logic [7:0]  Frame_Err_Cnt;
  logic        Overflow;
  logic        Clear_Status;

  logic [7:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  uart_frame_checker #(.DEPTH(4), .CNT_W(8)) dut (
    .UART_CLK       (UART_CLK),
    .UART_RESET     (UART_RESET),
    .Packet_In      (Packet_In),
    .Packet_Valid   (Packet_Valid),
    .Data_Out       (Data_Out),
    .Data_Valid     (Data_Valid),
    .Data_Ready     (Data_Ready),
    .Parity_Err_Cnt (Parity_Err_Cnt),
    .Frame_Err_Cnt  (Frame_Err_Cnt),
    .Overflow       (Overflow),
    .Clear_Status   (Clear_Status)
  );

  always #5 UART_CLK = ~UART_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted output byte must match the queue head.
  always @(negedge UART_CLK) begin
    if (!UART_RESET && Data_Valid && Data_Ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got %0h expected none", Data_Out);
      end else begin
        check("pop_data", int'(Data_Out), int'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [10:0] mk(input logic [7:0] b,
                                     input bit bad_par,
                                     input bit bad_start,
                                     input bit bad_stop);
    logic [10:0] f;
    f[10] = bad_start;
    for (int i = 0; i < 8; i++) f[9-i] = b[i];
    f[1] = (^b) ^ bad_par;
    f[0] = ~bad_stop;
    return f;
  endfunction

  task automatic cyc();
    @(posedge UART_CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge UART_CLK);
  endtask

  task automatic send(input logic [10:0] f, input bit store,
                      input logic [7:0] b);
    Packet_In    = f;
    Packet_Valid = 1'b1;
    if (store) exp_q.push_back(b);
    cyc();
    Packet_Valid = 1'b0;
  endtask

  task automatic drain();
    Data_Ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) cyc();
    cyc();
    sample();
    check("drain_left", exp_q.size(), 0);
    check("drain_valid", int'(Data_Valid), 0);
    cyc();
  endtask

  initial begin
    UART_RESET   = 1'b1;
    Packet_In    = '0;
    Packet_Valid = 1'b0;
    Data_Ready   = 1'b0;
    Clear_Status = 1'b0;
    cyc();
    cyc();
    UART_RESET = 1'b0;
    sample();
    check("rst_valid", int'(Data_Valid), 0);
    check("rst_data", int'(Data_Out), 0);
    check("rst_pcnt", int'(Parity_Err_Cnt), 0);
    check("rst_fcnt", int'(Frame_Err_Cnt), 0);
    check("rst_ovf", int'(Overflow), 0);
    cyc();

    // 1: good frame, one-cycle latency
    send(11'h295, 1'b1, 8'hA5);
    sample();
    check("t1_valid", int'(Data_Valid), 1);
    check("t1_data", int'(Data_Out), 8'hA5);
    check("t1_pcnt", int'(Parity_Err_Cnt), 0);
    check("t1_fcnt", int'(Frame_Err_Cnt), 0);
    cyc();
    Data_Ready = 1'b1;
    cyc();

    // 2: push into empty FIFO while ready, then a parity error
    send(11'h203, 1'b1, 8'h01);
    send(11'h297, 1'b0, 8'h00);
    sample();
    check("t2_pcnt", int'(Parity_Err_Cnt), 1);
    check("t2_valid", int'(Data_Valid), 0);
    cyc();

    // 3: framing errors, including one with start and stop issues
    send(11'h294, 1'b0, 8'h00);
    send(11'h695, 1'b0, 8'h00);
    send(mk(8'h3C, 1'b1, 1'b1, 1'b1), 1'b0, 8'h00);
    sample();
    check("t3_fcnt", int'(Frame_Err_Cnt), 3);
    check("t3_pcnt", int'(Parity_Err_Cnt), 1);
    check("t3_valid", int'(Data_Valid), 0);
    cyc();

    // 4: overflow with consumer stalled
    Data_Ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(mk(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0), i < 4, 8'h10 + 8'(i));
    sample();
    check("t4_ovf", int'(Overflow), 1);
    check("t4_valid", int'(Data_Valid), 1);
    check("t4_head", int'(Data_Out), 8'h10);
    cyc();
    drain();

    // 5: full FIFO, push coincident with pop
    Data_Ready   = 1'b0;
    Clear_Status = 1'b1;
    cyc();
    Clear_Status = 1'b0;
    sample();
    check("t5_clr_ovf", int'(Overflow), 0);
    check("t5_clr_fcnt", int'(Frame_Err_Cnt), 0);
    cyc();
    for (int i = 0; i < 4; i++)
      send(mk(8'h20 + 8'(i), 1'b0, 1'b0, 1'b0), 1'b1, 8'h20 + 8'(i));
    sample();
    check("t5_full_valid", int'(Data_Valid), 1);
    cyc();
    Packet_In    = mk(8'h30, 1'b0, 1'b0, 1'b0);
    Packet_Valid = 1'b1;
    Data_Ready   = 1'b1;
    exp_q.push_back(8'h30);
    cyc();
    Packet_Valid = 1'b0;
    Data_Ready   = 1'b0;
    sample();
    check("t5_ovf", int'(Overflow), 0);
    check("t5_head", int'(Data_Out), 8'h21);
    cyc();
    drain();
    Data_Ready = 1'b0;
    send(mk(8'h44, 1'b1, 1'b0, 1'b0), 1'b0, 8'h00);
    send(mk(8'h44, 1'b0, 1'b0, 1'b0), 1'b0, 8'h00);
    sample();
    check("t5_pre_pcnt", int'(Parity_Err_Cnt), 1);
    check("t5_pre_valid", int'(Data_Valid), 1);
    cyc();
    UART_RESET   = 1'b1;
    Clear_Status = 1'b1;
    Packet_In    = mk(8'h55, 1'b0, 1'b0, 1'b0);
    Packet_Valid = 1'b1;
    cyc();
    UART_RESET   = 1'b0;
    Clear_Status = 1'b0;
    Packet_Valid = 1'b0;
    sample();
    check("t5_rst_valid", int'(Data_Valid), 0);
    check("t5_rst_data", int'(Data_Out), 0);
    check("t5_rst_pcnt", int'(Parity_Err_Cnt), 0);
    check("t5_rst_fcnt", int'(Frame_Err_Cnt), 0);
    check("t5_rst_ovf", int'(Overflow), 0);
    cyc();

    // 6: saturation of the parity counter, then clear beats increment
    Packet_In    = mk(8'h5A, 1'b1, 1'b0, 1'b0);
    Packet_Valid = 1'b1;
    repeat (254) cyc();
    sample();
    check("t6_cnt254", int'(Parity_Err_Cnt), 254);
    cyc();
    repeat (5) cyc();
    sample();
    check("t6_sat", int'(Parity_Err_Cnt), 255);
    check("t6_fcnt", int'(Frame_Err_Cnt), 0);
    check("t6_valid", int'(Data_Valid), 0);
    cyc();
    Clear_Status = 1'b1;
    cyc();
    Clear_Status = 1'b0;
    Packet_Valid = 1'b0;
    sample();
    check("t6_clr", int'(Parity_Err_Cnt), 0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
